// File: rtl/vga_sprite_display.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : vga_sprite_display
// Brief    : VGA timing generator that overlays one monochrome ROM image at a
//            programmable position. Define VGA_SPRITE_SCALE2X_EN for 2x zoom.
// Revision : 1.0 - initial release
// ============================================================================
module vga_sprite_display #(
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 40,
    parameter int H_SYNC   = 128,
    parameter int H_BP     = 88,
    parameter int V_ACTIVE = 600,
    parameter int V_FP     = 1,
    parameter int V_SYNC   = 4,
    parameter int V_BP     = 23,
    parameter bit SYNC_POL = 1'b1,
    parameter int IMG_W    = 256,
    parameter int IMG_H    = 256,
    parameter int ADDR_W   = 11,
    parameter int ROM_LAT  = 1,
    parameter int COLOR_W  = 1
) (
    input  logic                   CLK_40M,
    input  logic                   RSTn,
    input  logic [10:0]            pos_x,
    input  logic [10:0]            pos_y,
    input  logic [3*COLOR_W-1:0]   fg_rgb,
    input  logic [3*COLOR_W-1:0]   bg_rgb,
    output logic [ADDR_W-1:0]      rom_addr,
    input  logic [IMG_W-1:0]       rom_data,
    output logic [COLOR_W-1:0]     vga_red,
    output logic [COLOR_W-1:0]     vga_green,
    output logic [COLOR_W-1:0]     vga_blue,
    output logic                   hsync_sig,
    output logic                   vsync_sig,
    output logic                   frame_start
);

    localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int c_HW      = $clog2(c_H_TOTAL);
    localparam int c_VW      = $clog2(c_V_TOTAL);
    localparam int c_CW_MAX  = (c_HW > c_VW) ? c_HW : c_VW;
    localparam int c_AW      = ((c_CW_MAX > 11) ? c_CW_MAX : 11) + 1;
    localparam int c_IW      = (IMG_W > 1) ? $clog2(IMG_W) : 1;
`ifdef VGA_SPRITE_SCALE2X_EN
    localparam int c_SHIFT   = 1;
`else
    localparam int c_SHIFT   = 0;
`endif

    localparam logic [c_AW-1:0] c_SPAN_W    = c_AW'(IMG_W << c_SHIFT);
    localparam logic [c_AW-1:0] c_SPAN_H    = c_AW'(IMG_H << c_SHIFT);
    localparam logic [c_AW-1:0] c_H_ACT     = c_AW'(H_ACTIVE);
    localparam logic [c_AW-1:0] c_V_ACT     = c_AW'(V_ACTIVE);
    localparam logic [c_HW-1:0] c_H_LAST    = c_HW'(c_H_TOTAL - 1);
    localparam logic [c_VW-1:0] c_V_LAST    = c_VW'(c_V_TOTAL - 1);
    localparam logic [c_HW-1:0] c_H_FETCH   = c_HW'(H_ACTIVE);
    localparam logic [c_HW-1:0] c_H_CAPTURE = c_HW'(H_ACTIVE + 1 + ROM_LAT);
    localparam logic [c_HW-1:0] c_HS_START  = c_HW'(H_ACTIVE + H_FP);
    localparam logic [c_HW-1:0] c_HS_END    = c_HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [c_VW-1:0] c_VS_START  = c_VW'(V_ACTIVE + V_FP);
    localparam logic [c_VW-1:0] c_VS_END    = c_VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [c_VW-1:0] c_V_LATCH   = c_VW'(V_ACTIVE);
    localparam logic            c_SYNC_OFF  = ~SYNC_POL;

    logic [c_HW-1:0]        r_h_cnt;
    logic [c_VW-1:0]        r_v_cnt;
    logic [10:0]            r_px;
    logic [10:0]            r_py;
    logic [ADDR_W-1:0]      r_rom_addr;
    logic                   r_fetch_ok;
    logic [IMG_W-1:0]       r_row_reg;
    logic                   r_row_valid;
    logic [3*COLOR_W-1:0]   r_rgb;
    logic                   r_hsync;
    logic                   r_vsync;
    logic                   r_frame_start;

    logic                   w_h_last;
    logic                   w_v_last;
    logic [c_AW-1:0]        w_h_x;
    logic [c_AW-1:0]        w_v_x;
    logic [c_AW-1:0]        w_px_x;
    logic [c_AW-1:0]        w_py_x;
    logic [c_AW-1:0]        w_nv;
    logic [c_AW-1:0]        w_ry;
    logic                   w_fetch_ok;
    logic [ADDR_W-1:0]      w_row_idx;
    logic [c_AW-1:0]        w_dx;
    logic [c_IW-1:0]        w_bit_idx;
    logic                   w_active;
    logic                   w_inside;
    logic                   w_pix_on;
    logic                   w_hs_on;
    logic                   w_vs_on;

    assign w_h_last = (r_h_cnt == c_H_LAST);
    assign w_v_last = (r_v_cnt == c_V_LAST);
    assign w_h_x    = c_AW'(r_h_cnt);
    assign w_v_x    = c_AW'(r_v_cnt);
    assign w_px_x   = c_AW'(r_px);
    assign w_py_x   = c_AW'(r_py);

    always_ff @(posedge CLK_40M or negedge RSTn) begin
        if (!RSTn) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_h_last) begin
            r_h_cnt <= '0;
            r_v_cnt <= w_v_last ? '0 : r_v_cnt + c_VW'(1);
        end else begin
            r_h_cnt <= r_h_cnt + c_HW'(1);
        end
    end

    // Position only moves at the start of vertical blank so a frame never tears.
    always_ff @(posedge CLK_40M or negedge RSTn) begin
        if (!RSTn) begin
            r_px <= '0;
            r_py <= '0;
        end else if ((r_h_cnt == '0) && (r_v_cnt == c_V_LATCH)) begin
            r_px <= pos_x;
            r_py <= pos_y;
        end
    end

    // Row for the upcoming line; rows below the visible area are never fetched.
    always_comb begin
        w_nv       = w_v_last ? '0 : w_v_x + c_AW'(1);
        w_ry       = w_nv - w_py_x;
        w_fetch_ok = (w_py_x <= w_nv) && (w_nv < c_V_ACT) && (w_ry < c_SPAN_H);
        w_row_idx  = ADDR_W'(w_ry >> c_SHIFT);
    end

    always_ff @(posedge CLK_40M or negedge RSTn) begin
        if (!RSTn) begin
            r_rom_addr  <= '0;
            r_fetch_ok  <= 1'b0;
            r_row_reg   <= '0;
            r_row_valid <= 1'b0;
        end else begin
            if (r_h_cnt == c_H_FETCH) begin
                r_fetch_ok <= w_fetch_ok;
                if (w_fetch_ok) begin
                    r_rom_addr <= w_row_idx;
                end
            end
            // ROM samples the address one cycle after it changes, then ROM_LAT more.
            if (r_h_cnt == c_H_CAPTURE) begin
                r_row_reg   <= r_fetch_ok ? rom_data : '0;
                r_row_valid <= r_fetch_ok;
            end
        end
    end

    always_comb begin
        w_active  = (w_h_x < c_H_ACT) && (w_v_x < c_V_ACT);
        w_dx      = w_h_x - w_px_x;
        w_bit_idx = c_IW'(IMG_W - 1) - c_IW'(w_dx >> c_SHIFT);
        w_inside  = w_active && r_row_valid && (w_px_x <= w_h_x) && (w_dx < c_SPAN_W);
        w_pix_on  = w_inside && r_row_reg[w_bit_idx];
        w_hs_on   = (r_h_cnt >= c_HS_START) && (r_h_cnt < c_HS_END);
        w_vs_on   = (r_v_cnt >= c_VS_START) && (r_v_cnt < c_VS_END);
    end

    always_ff @(posedge CLK_40M or negedge RSTn) begin
        if (!RSTn) begin
            r_rgb         <= '0;
            r_hsync       <= c_SYNC_OFF;
            r_vsync       <= c_SYNC_OFF;
            r_frame_start <= 1'b0;
        end else begin
            if (!w_active) begin
                r_rgb <= '0;
            end else if (w_pix_on) begin
                r_rgb <= fg_rgb;
            end else begin
                r_rgb <= bg_rgb;
            end
            r_hsync       <= w_hs_on ? SYNC_POL : c_SYNC_OFF;
            r_vsync       <= w_vs_on ? SYNC_POL : c_SYNC_OFF;
            r_frame_start <= (r_h_cnt == '0) && (r_v_cnt == '0);
        end
    end

    assign rom_addr    = r_rom_addr;
    assign vga_red     = r_rgb[3*COLOR_W-1:2*COLOR_W];
    assign vga_green   = r_rgb[2*COLOR_W-1:COLOR_W];
    assign vga_blue    = r_rgb[COLOR_W-1:0];
    assign hsync_sig   = r_hsync;
    assign vsync_sig   = r_vsync;
    assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_vga_sprite_display.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_vga_sprite_display
// Brief    : Scoreboard bench for vga_sprite_display on a reduced raster.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_sprite_display;

    localparam int c_H_ACTIVE = 40;
    localparam int c_H_FP     = 4;
    localparam int c_H_SYNC   = 8;
    localparam int c_H_BP     = 6;
    localparam int c_V_ACTIVE = 30;
    localparam int c_V_FP     = 1;
    localparam int c_V_SYNC   = 2;
    localparam int c_V_BP     = 3;
    localparam int c_H_TOTAL  = c_H_ACTIVE + c_H_FP + c_H_SYNC + c_H_BP;
    localparam int c_V_TOTAL  = c_V_ACTIVE + c_V_FP + c_V_SYNC + c_V_BP;
    localparam bit c_SYNC_POL = 1'b1;
    localparam bit c_SYNC_OFF = ~c_SYNC_POL;
    localparam int c_IMG_W    = 16;
    localparam int c_IMG_H    = 8;
    localparam int c_ADDR_W   = 4;
    localparam int c_ROM_LAT  = 2;
`ifdef VGA_SPRITE_SCALE2X_EN
    localparam int c_SH       = 1;
`else
    localparam int c_SH       = 0;
`endif
    localparam int c_EXP_MAX_ADDR = (c_V_ACTIVE - 1 - 26) >> c_SH;

    logic                clk;
    logic                rst_n;
    logic [10:0]         pos_x;
    logic [10:0]         pos_y;
    logic [2:0]          fg_rgb;
    logic [2:0]          bg_rgb;
    logic [c_ADDR_W-1:0] rom_addr;
    logic [c_IMG_W-1:0]  rom_data;
    logic                vga_red;
    logic                vga_green;
    logic                vga_blue;
    logic                hsync_sig;
    logic                vsync_sig;
    logic                frame_start;

    vga_sprite_display #(
        .H_ACTIVE (c_H_ACTIVE), .H_FP (c_H_FP), .H_SYNC (c_H_SYNC), .H_BP (c_H_BP),
        .V_ACTIVE (c_V_ACTIVE), .V_FP (c_V_FP), .V_SYNC (c_V_SYNC), .V_BP (c_V_BP),
        .SYNC_POL (c_SYNC_POL), .IMG_W (c_IMG_W), .IMG_H (c_IMG_H),
        .ADDR_W   (c_ADDR_W),   .ROM_LAT (c_ROM_LAT), .COLOR_W (1)
    ) u_dut (
        .CLK_40M     (clk),
        .RSTn        (rst_n),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .fg_rgb      (fg_rgb),
        .bg_rgb      (bg_rgb),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .vga_red     (vga_red),
        .vga_green   (vga_green),
        .vga_blue    (vga_blue),
        .hsync_sig   (hsync_sig),
        .vsync_sig   (vsync_sig),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [c_IMG_W-1:0] rom_word(input int r);
        logic [31:0] t;
        t = 32'h0000_C5A3 ^ (32'(r) * 32'h0000_1111);
        return t[c_IMG_W-1:0];
    endfunction

    // Synchronous ROM with c_ROM_LAT cycles of read latency.
    logic [c_IMG_W-1:0] rom_pipe [c_ROM_LAT];
    always @(posedge clk) begin
        rom_pipe[0] <= rom_word(int'(rom_addr));
        for (int i = 1; i < c_ROM_LAT; i++) begin
            rom_pipe[i] <= rom_pipe[i-1];
        end
    end
    assign rom_data = rom_pipe[c_ROM_LAT-1];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [5:0] val;
        int         h;
        int         v;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;
    int   m_h = 0;
    int   m_v = 0;
    int   m_frame = 0;
    int   m_px = 0;
    int   m_py = 0;
    bit   m_row0_ok = 1'b0;

    // Reference picture: what pixel (h,v) should show, independent of pipelining.
    function automatic logic [5:0] model_out(input int h, input int v);
        logic [2:0]         rgb;
        logic [c_IMG_W-1:0] w;
        int                 dx;
        int                 dy;
        logic               hs;
        logic               vs;
        rgb = 3'b000;
        if (h < c_H_ACTIVE && v < c_V_ACTIVE) begin
            rgb = bg_rgb;
            dx  = h - m_px;
            dy  = v - m_py;
            if (dx >= 0 && dx < (c_IMG_W << c_SH) && dy >= 0 && dy < (c_IMG_H << c_SH)
                && (v != 0 || m_row0_ok)) begin
                w = rom_word(dy >> c_SH);
                if (w[c_IMG_W-1-(dx >> c_SH)]) rgb = fg_rgb;
            end
        end
        hs = (h >= c_H_ACTIVE + c_H_FP) && (h < c_H_ACTIVE + c_H_FP + c_H_SYNC);
        vs = (v >= c_V_ACTIVE + c_V_FP) && (v < c_V_ACTIVE + c_V_FP + c_V_SYNC);
        return {rgb, hs ? c_SYNC_POL : c_SYNC_OFF, vs ? c_SYNC_POL : c_SYNC_OFF,
                (h == 0 && v == 0)};
    endfunction

    // Push expectation for the current raster position; pop the one the DUT now shows.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sb.delete();
                m_h       = 0;
                m_v       = 0;
                m_px      = 0;
                m_py      = 0;
                m_row0_ok = 1'b0;
            end else begin
                if (sb.size() > 0) begin
                    m_e = sb.pop_front();
                    check($sformatf("pix h%0d v%0d", m_e.h, m_e.v),
                          32'({vga_red, vga_green, vga_blue, hsync_sig, vsync_sig, frame_start}),
                          32'(m_e.val));
                end
                m_e.val = model_out(m_h, m_v);
                m_e.h   = m_h;
                m_e.v   = m_v;
                sb.push_back(m_e);
                if (m_h == 0 && m_v == c_V_ACTIVE) begin
                    m_px = int'(pos_x);
                    m_py = int'(pos_y);
                end
                if (m_h == c_H_TOTAL - 1) begin
                    m_h = 0;
                    if (m_v == c_V_TOTAL - 1) begin
                        m_v       = 0;
                        m_row0_ok = 1'b1;
                        m_frame++;
                    end else begin
                        m_v++;
                    end
                end else begin
                    m_h++;
                end
            end
        end
    end

    task automatic wait_pos(input int frame, input int line);
        int budget;
        budget = 4 * c_H_TOTAL * c_V_TOTAL;
        while (!(m_frame == frame && m_v == line && m_h == 0) && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        check($sformatf("reach f%0d l%0d", frame, line),
              {m_frame[15:0], m_v[15:0]}, {frame[15:0], line[15:0]});
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, " rgb"}, 32'({vga_red, vga_green, vga_blue}), 32'd0);
        check({pfx, " hsync"}, 32'(hsync_sig), 32'(c_SYNC_OFF));
        check({pfx, " vsync"}, 32'(vsync_sig), 32'(c_SYNC_OFF));
        check({pfx, " frame_start"}, 32'(frame_start), 32'd0);
        check({pfx, " rom_addr"}, 32'(rom_addr), 32'd0);
    endtask

    int max_addr;

    initial begin
        rst_n  = 1'b0;
        pos_x  = 11'd0;
        pos_y  = 11'd0;
        fg_rgb = 3'b110;
        bg_rgb = 3'b001;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        #1 rst_n = 1'b1;

        // Frames 0-1 at the origin; move requested mid frame 1 must wait for frame 2.
        wait_pos(1, 15);
        pos_x = 11'd5;
        pos_y = 11'd3;
        wait_pos(2, 8);
        fg_rgb = 3'b011;
        bg_rgb = 3'b100;
        wait_pos(2, 20);
        pos_x = 11'd34;
        pos_y = 11'd26;

        // Frame 3 clipped at the bottom-right corner.
        wait_pos(3, 27);
        max_addr = 0;
        for (int i = 0; i < c_H_TOTAL * (c_V_TOTAL - 27); i++) begin
            @(posedge clk);
            #1;
            if (int'(rom_addr) > max_addr) max_addr = int'(rom_addr);
        end
        check("max rom_addr", 32'(max_addr), 32'(c_EXP_MAX_ADDR));

        // Asynchronous reset in the middle of frame 4.
        wait_pos(4, 12);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        // First frame after reset draws at the origin; then position off-screen.
        wait_pos(4, 5);
        pos_x = 11'd45;
        pos_y = 11'd2;
        wait_pos(6, 2);
        repeat (2) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
